// File: rtl/hazard_scoreboard_unit_if.sv
// Bundle of ID-stage request, control and scoreboard status signals between
// the pipeline core (master) and the hazard/forwarding controller (slave).
interface hazard_scoreboard_unit_if #(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = 16
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic                          id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
  logic [NUM_SRC-1:0]            id_src_valid;
  logic [REG_ADDR_W-1:0]         id_dest;
  logic                          id_wb_en;
  logic                          id_mem_r_en;
  logic                          forward_en;
  logic                          freeze;
  logic                          flush;
  logic                          clr_stats;
  logic                          hazard_detected;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
  logic [DEPTH-1:0]              sb_valid;
  logic [CNT_W-1:0]              stall_count;

  modport master (
    output id_valid, id_src, id_src_valid, id_dest, id_wb_en, id_mem_r_en,
           forward_en, freeze, flush, clr_stats,
    input  hazard_detected, fwd_sel, sb_valid, stall_count
  );

  modport slave (
    input  id_valid, id_src, id_src_valid, id_dest, id_wb_en, id_mem_r_en,
           forward_en, freeze, flush, clr_stats,
    output hazard_detected, fwd_sel, sb_valid, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Hazard detection and forwarding select generation from a shift-register
// scoreboard of in-flight writers (slot 0 = EXE, slot 1 = MEM, ...).
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_READY = 1,
  parameter int CNT_W      = 16
) (
  input logic                    clk,
  input logic                    rst,
  hazard_scoreboard_unit_if.slave bus
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [DEPTH-1:0]                 load_q, load_d;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] dest_q, dest_d;
  logic [NUM_SRC*SEL_W-1:0]         fwd_sel_q, fwd_sel_d;
  logic [CNT_W-1:0]                 stall_count_q, stall_count_d;

  logic [NUM_SRC-1:0][DEPTH-1:0]    match;
  logic [NUM_SRC*SEL_W-1:0]         fwd_next;
  logic [SEL_W-1:0]                 sel;
  logic                             hz_raw;
  logic                             hazard;
  logic                             enter;

  always_comb begin
    match    = '0;
    hz_raw   = 1'b0;
    fwd_next = '0;
    sel      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        match[i][j] = bus.id_valid & bus.id_src_valid[i] & valid_q[j] &
                      (dest_q[j] == bus.id_src[i*REG_ADDR_W +: REG_ADDR_W]);
        // With forwarding, only a load too young to have its data stalls.
        if (match[i][j] && (!bus.forward_en || (load_q[j] && (j < LOAD_READY))))
          hz_raw = 1'b1;
      end
      // Scan oldest to youngest so the youngest matching writer wins.
      sel = '0;
      for (int j = DEPTH - 1; j >= 0; j--) begin
        if (match[i][j])
          sel = SEL_W'(j + 1);
      end
      if (!bus.forward_en)
        sel = '0;
      fwd_next[i*SEL_W +: SEL_W] = sel;
    end

    hazard = hz_raw & bus.id_valid & ~bus.flush;
    enter  = bus.id_valid & bus.id_wb_en & ~hazard & ~bus.flush;

    valid_d       = valid_q;
    load_d        = load_q;
    dest_d        = dest_q;
    fwd_sel_d     = fwd_sel_q;
    stall_count_d = stall_count_q;
    if (!bus.freeze) begin
      valid_d   = {valid_q[DEPTH-2:0], enter};
      load_d    = {load_q[DEPTH-2:0], enter & bus.id_mem_r_en};
      dest_d[0] = enter ? bus.id_dest : '0;
      for (int j = 1; j < DEPTH; j++)
        dest_d[j] = dest_q[j-1];
      fwd_sel_d = enter ? fwd_next : '0;
      if (hazard && (stall_count_q != {CNT_W{1'b1}}))
        stall_count_d = stall_count_q + CNT_W'(1);
    end
    if (bus.clr_stats)
      stall_count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      load_q        <= '0;
      dest_q        <= '0;
      fwd_sel_q     <= '0;
      stall_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      load_q        <= load_d;
      dest_q        <= dest_d;
      fwd_sel_q     <= fwd_sel_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.hazard_detected = hazard;
  assign bus.fwd_sel         = fwd_sel_q;
  assign bus.sb_valid        = valid_q;
  assign bus.stall_count     = stall_count_q;
endmodule
